// File: rtl/noc_ingress_buffer_if.sv
// Handshake bundle between a packet source, the ingress buffer and the switch input.
// Signals:
//   in_pkt, in_valid, in_ready          source -> buffer packet channel
//   out_pkt, out_dest_oh, out_valid,
//   out_ready                           buffer -> switch channel with one-hot route
// Modports:
//   slave  - the ingress buffer
//   master - the environment (source and switch side)
interface noc_ingress_buffer_if #(
  parameter int unsigned PKT_WIDTH = 64,
  parameter int unsigned N_PORTS   = 4
) ();
  logic [PKT_WIDTH-1:0] in_pkt;
  logic                 in_valid;
  logic                 in_ready;
  logic [PKT_WIDTH-1:0] out_pkt;
  logic [N_PORTS-1:0]   out_dest_oh;
  logic                 out_valid;
  logic                 out_ready;

  modport slave (
    input  in_pkt, in_valid, out_ready,
    output in_ready, out_pkt, out_dest_oh, out_valid
  );

  modport master (
    output in_pkt, in_valid, out_ready,
    input  in_ready, out_pkt, out_dest_oh, out_valid
  );
endinterface

// File: rtl/noc_ingress_buffer.sv
// Per-port NoC ingress buffer: FIFO of incoming packets, destination decode to a
// one-hot routing request, drop of packets with an illegal destination, and a
// congestion flag driven by occupancy against a high watermark.
// Ports:
//   clk, rst_n   fabric clock, asynchronous active-low reset
//   flush        synchronous discard of all stored packets
//   bus          noc_ingress_buffer_if.slave (input and output handshakes)
//   congested    occupancy >= HI_WM
//   occupancy    stored-entry count
//   pkt_in_cnt   packets stored, pkt_out_cnt packets delivered, drop_cnt packets dropped
// Optional feature: define ING_TELEMETRY_EN to build the saturating event counters;
// otherwise the counter ports read 0 and no counter flops exist.
module noc_ingress_buffer #(
  parameter int unsigned N_PORTS   = 4,
  parameter int unsigned PKT_WIDTH = 64,
  parameter int unsigned DEPTH     = 8,
  parameter int unsigned DEST_LSB  = 56,
  parameter int unsigned DEST_W    = 4,
  parameter int unsigned HI_WM     = 6
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     flush,
  noc_ingress_buffer_if.slave      bus,
  output logic                     congested,
  output logic [$clog2(DEPTH):0]   occupancy,
  output logic [31:0]              pkt_in_cnt,
  output logic [31:0]              pkt_out_cnt,
  output logic [31:0]              drop_cnt
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [PKT_WIDTH-1:0] mem      [DEPTH];
  logic [N_PORTS-1:0]   dest_mem [DEPTH];

  logic [AW-1:0]        wr_ptr;
  logic [AW-1:0]        rd_ptr;
  logic [CW-1:0]        count;

  logic [DEST_W-1:0]    dest;
  logic                 dest_legal;
  logic [N_PORTS-1:0]   dest_oh;
  logic                 in_hs;
  logic                 push;
  logic                 pop;
  logic                 drop;

  // in_ready and out_valid come only from the registered count, so out_ready
  // never reaches in_ready combinationally.
  assign bus.in_ready  = (count != CW'(DEPTH));
  assign bus.out_valid = (count != '0);
  assign occupancy     = count;
  assign congested     = (count >= CW'(HI_WM));

  // Storage is not reset; the head is masked so the outputs read 0 while empty.
  assign bus.out_pkt     = bus.out_valid ? mem[rd_ptr]      : '0;
  assign bus.out_dest_oh = bus.out_valid ? dest_mem[rd_ptr] : '0;

  assign dest       = bus.in_pkt[DEST_LSB +: DEST_W];
  assign dest_legal = (32'(dest) < N_PORTS);

  always_comb begin
    dest_oh = '0;
    for (int unsigned i = 0; i < N_PORTS; i++) begin
      dest_oh[i] = (dest == DEST_W'(i));
    end
  end

  // Flush overrides both sides: a same-cycle push is discarded and a same-cycle
  // pop is not treated as a delivery.
  assign in_hs = bus.in_valid && bus.in_ready;
  assign push  = in_hs && dest_legal && !flush;
  assign drop  = in_hs && !dest_legal && !flush;
  assign pop   = bus.out_valid && bus.out_ready && !flush;

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr]      <= bus.in_pkt;
      dest_mem[wr_ptr] <= dest_oh;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

`ifdef ING_TELEMETRY_EN
  logic [31:0] in_cnt_q;
  logic [31:0] out_cnt_q;
  logic [31:0] drop_cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      in_cnt_q   <= '0;
      out_cnt_q  <= '0;
      drop_cnt_q <= '0;
    end else begin
      if (push && (in_cnt_q != '1))   in_cnt_q   <= in_cnt_q + 1'b1;
      if (pop  && (out_cnt_q != '1))  out_cnt_q  <= out_cnt_q + 1'b1;
      if (drop && (drop_cnt_q != '1)) drop_cnt_q <= drop_cnt_q + 1'b1;
    end
  end

  assign pkt_in_cnt  = in_cnt_q;
  assign pkt_out_cnt = out_cnt_q;
  assign drop_cnt    = drop_cnt_q;
`else
  // Illegal-destination packets are still consumed and discarded; only the
  // bookkeeping is absent.
  logic unused_drop;
  assign unused_drop = drop;
  assign pkt_in_cnt  = '0;
  assign pkt_out_cnt = '0;
  assign drop_cnt    = '0;
`endif

endmodule
